// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: next-PC select encodings, NOP word,
// base opcodes and the fetch-stage state enum.
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_SEL_PC4    = 2'd0,
        PC_SEL_JAL    = 2'd1,
        PC_SEL_JALR   = 2'd2,
        PC_SEL_BRANCH = 2'd3
    } pc_sel_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_STALL,
        FETCH_DROP
    } fetch_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: sequential pc+4, or the stage-2 target chosen by sel
// when a redirect is in progress. Purely combinational.
module next_pc_mux
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            redirect,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc
);

    // Sequential advance unless redirecting; jalr clears bit 0 of its target
    always_comb begin
        next_pc = pc + XLEN'(4);
        if (redirect) begin
            case (sel)
                PC_SEL_JAL:    next_pc = jal_target;
                PC_SEL_JALR:   next_pc = {jalr_target[XLEN-1:1], 1'b0};
                PC_SEL_BRANCH: next_pc = branch_target;
                default:       next_pc = pc + XLEN'(4);
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage (pipeline stages 0/1): owns the PC, issues instruction-memory
// reads with at most one outstanding, and fills the IF/ID register.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_count / flush_count.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_next_address_sel,
    input  logic            should_stall_0_1,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_ready,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_ins,
    output logic [XLEN-1:0] if_id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     flush_count
`endif
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INS);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] pend_ins_q, pend_ins_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_ins_q, if_id_ins_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;

    logic [XLEN-1:0] next_pc;
    logic            room;
    logic            accept;
    logic            req;
    logic            if_id_load;
    logic [XLEN-1:0] load_ins;
    logic [XLEN-1:0] load_pc;

    next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
        .redirect      (should_stall_0_1),
        .sel           (pc_next_address_sel),
        .pc            (pc_q),
        .jal_target    (jal_target),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    // FSM next state, memory request, PC advance and IF/ID update
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        pend_ins_d    = pend_ins_q;
        pend_pc_d     = pend_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_ins_d   = if_id_ins_q;
        if_id_pc_d    = if_id_pc_q;
        req           = 1'b0;
        accept        = 1'b0;
        if_id_load    = 1'b0;
        load_ins      = imem_rdata;
        load_pc       = inflight_pc_q;
        room          = !if_id_valid_q || id_ready;

        if (if_id_valid_q && id_ready) begin
            if_id_valid_d = 1'b0;
            if_id_ins_d   = NOP;
        end

        case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                req = 1'b1;
                if (imem_ready) begin
                    accept  = 1'b1;
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid && !should_stall_0_1) begin
                    if (room) begin
                        if_id_load = 1'b1;
                        req        = 1'b1;
                        if (imem_ready) begin
                            accept = 1'b1;
                        end else begin
                            state_d = FETCH_REQ;
                        end
                    end else begin
                        // Decode refused the previous word after this read was
                        // issued: park the response until IF/ID drains.
                        pend_ins_d = imem_rdata;
                        pend_pc_d  = inflight_pc_q;
                        state_d    = FETCH_STALL;
                    end
                end
            end
            FETCH_STALL: begin
                if (id_ready) begin
                    if_id_load = 1'b1;
                    load_ins   = pend_ins_q;
                    load_pc    = pend_pc_q;
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (if_id_load) begin
            if_id_valid_d = 1'b1;
            if_id_ins_d   = load_ins;
            if_id_pc_d    = load_pc;
        end

        if (accept) begin
            inflight_pc_d = pc_q;
            pc_d          = next_pc;
        end

        // Redirect overrides everything above. A response arriving in the
        // redirect cycle retires the outstanding read, so WAIT/DROP go
        // straight to REQ instead of waiting for a reply that never comes.
        if (should_stall_0_1) begin
            pc_d          = next_pc;
            if_id_valid_d = 1'b0;
            if_id_ins_d   = NOP;
            if_id_pc_d    = if_id_pc_q;
            case (state_q)
                FETCH_WAIT: state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
                FETCH_REQ:  state_d = imem_ready  ? FETCH_DROP : FETCH_REQ;
                FETCH_DROP: state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
                default:    state_d = FETCH_REQ;
            endcase
        end
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            pend_ins_q    <= NOP;
            pend_pc_q     <= '0;
            if_id_valid_q <= 1'b0;
            if_id_ins_q   <= NOP;
            if_id_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            pend_ins_q    <= pend_ins_d;
            pend_pc_q     <= pend_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_ins_q   <= if_id_ins_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_ins   = if_id_ins_q;
    assign if_id_pc    = if_id_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Count IF/ID writes not squashed in the same cycle, and redirect cycles
    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (if_id_load && !should_stall_0_1) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (should_stall_0_1) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: randomized memory latency, decode
// backpressure and redirects checked against a program-order fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_next_address_sel = '0;
    logic        should_stall_0_1 = 1'b0;
    logic [31:0] jal_target = '0;
    logic [31:0] jalr_target = '0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_ready = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_ins;
    logic [31:0] if_id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_next_address_sel (pc_next_address_sel),
        .should_stall_0_1    (should_stall_0_1),
        .jal_target          (jal_target),
        .jalr_target         (jalr_target),
        .branch_target       (branch_target),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .id_ready            (id_ready),
        .if_id_valid         (if_id_valid),
        .if_id_ins           (if_id_ins),
        .if_id_pc            (if_id_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count         (fetch_count),
        .flush_count         (flush_count)
`endif
    );

    int checks = 0;
    int passed = 0;

    // stimulus knobs
    int ready_pct = 100;
    int idr_pct   = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    int rd_pct    = 0;
    bit          force_rd = 1'b0;
    logic [1:0]  force_sel = '0;
    logic [31:0] force_tgt = '0;

    // reference model: architectural fetch pointer and program-order stream
    logic [31:0] fetch_ptr = '0;
    logic [31:0] exp_consume = '0;
    bit          expect_invalid = 1'b0;
    bit          hold_valid = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_ins = '0;
    bit          prev_unacc = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    int          n_flush = 0;
    int          n_cons = 0;

    // memory model: one outstanding read
    bit          mem_busy = 1'b0;
    bit          epoch_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    logic [31:0] cons_q[$];
    int          cyc = 0;

    bit          s_req = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_ifid_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        logic [31:0] tgt;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
        imem_ready = (mem_busy && !imem_rvalid) ? 1'b0 : ($urandom_range(99) < ready_pct);
        id_ready   = ($urandom_range(99) < idr_pct);
        jal_target    = $urandom & 32'hFFFF_FFFC;
        jalr_target   = $urandom;
        branch_target = $urandom & 32'hFFFF_FFFC;
        if (force_rd) begin
            should_stall_0_1    = 1'b1;
            pc_next_address_sel = force_sel;
            case (force_sel)
                2'd1: jal_target    = force_tgt;
                2'd2: jalr_target   = force_tgt;
                2'd3: branch_target = force_tgt;
                default: ;
            endcase
            force_rd = 1'b0;
        end else begin
            should_stall_0_1    = ($urandom_range(99) < rd_pct);
            pc_next_address_sel = 2'($urandom_range(3));
        end
        #1;
        s_req     = imem_req;
        s_addr    = imem_addr;
        s_ifid_pc = if_id_pc;

        // IF/ID register
        if (expect_invalid) chk("flush_clears_valid", 32'(if_id_valid), 32'd0);
        if (hold_valid) begin
            chk("hold_valid", 32'(if_id_valid), 32'd1);
            chk("hold_pc", if_id_pc, hold_pc);
            chk("hold_ins", if_id_ins, hold_ins);
        end
        if (!if_id_valid) begin
            chk("nop_when_invalid", if_id_ins, NOP);
        end else if (id_ready && !should_stall_0_1) begin
            chk("consume_pc", if_id_pc, exp_consume);
            chk("consume_ins", if_id_ins, mem_word(exp_consume));
            cons_q.push_back(if_id_pc);
            exp_consume += 32'd4;
            n_cons++;
        end
        hold_valid     = if_id_valid && !id_ready && !should_stall_0_1;
        hold_pc        = if_id_pc;
        hold_ins       = if_id_ins;
        expect_invalid = should_stall_0_1;

        // memory interface
        if (prev_unacc && !prev_stall) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, prev_addr);
        end
        if (epoch_busy && !imem_rvalid) chk("no_req_while_outstanding", 32'(imem_req), 32'd0);
        prev_unacc = imem_req && !imem_ready;
        prev_stall = should_stall_0_1;
        prev_addr  = imem_addr;

        if (imem_rvalid) begin
            mem_busy   = 1'b0;
            epoch_busy = 1'b0;
        end
        if (imem_req && imem_ready) begin
            chk("accept_addr", imem_addr, fetch_ptr);
            acc_q.push_back(imem_addr);
            acc_cyc.push_back(cyc);
            mem_busy   = 1'b1;
            epoch_busy = 1'b1;
            mem_addr   = imem_addr;
            mem_cnt    = int'($urandom_range(lat_max - 1, lat_min - 1));
            if (!should_stall_0_1) fetch_ptr += 32'd4;
        end

        if (should_stall_0_1) begin
            case (pc_next_address_sel)
                2'd1:    tgt = jal_target;
                2'd2:    tgt = jalr_target & 32'hFFFF_FFFE;
                2'd3:    tgt = branch_target;
                default: tgt = fetch_ptr + 32'd4;
            endcase
            fetch_ptr   = tgt;
            exp_consume = tgt;
            n_flush++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        should_stall_0_1 = 1'b0;
        imem_rvalid      = 1'b0;
        imem_ready       = 1'b0;
        id_ready         = 1'b0;
        #1;
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_valid", 32'(if_id_valid), 32'd0);
        chk("reset_ins", if_id_ins, NOP);
        chk("reset_pc", if_id_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst_n          = 1'b1;
        fetch_ptr      = 32'h0000_0000;
        exp_consume    = 32'h0000_0000;
        expect_invalid = 1'b0;
        hold_valid     = 1'b0;
        prev_unacc     = 1'b0;
        epoch_busy     = 1'b0;
        n_flush        = 0;
        n_cons         = 0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (acc_q.size() < n) begin
            checks++;
            $display("FAIL %s: timeout, got %0d accepts expected %0d", name, acc_q.size(), n);
        end
    endtask

    task automatic wait_cons(input int n, input int budget, input string name);
        int k = 0;
        while (cons_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (cons_q.size() < n) begin
            checks++;
            $display("FAIL %s: timeout, got %0d consumes expected %0d", name, cons_q.size(), n);
        end
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] tgt);
        force_rd  = 1'b1;
        force_sel = sel;
        force_tgt = tgt;
        step();
        acc_q.delete();
        acc_cyc.delete();
        cons_q.delete();
    endtask

    initial begin
        int k;
        int cons_before;
        logic [31:0] held_addr;

        // 1: back-to-back fetch with zero-wait memory
        do_reset();
        acc_q.delete(); acc_cyc.delete(); cons_q.delete();
        repeat (6) step();
        if (acc_q.size() >= 3 && cons_q.size() >= 3) begin
            chk("t1_addr0", acc_q[0], 32'h0);
            chk("t1_addr1", acc_q[1], 32'h4);
            chk("t1_addr2", acc_q[2], 32'h8);
            chk("t1_back_to_back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
            chk("t1_cons0", cons_q[0], 32'h0);
            chk("t1_cons2", cons_q[2], 32'h8);
        end else begin
            checks++;
            $display("FAIL t1_throughput: got %0d accepts expected 6", acc_q.size());
        end

        // 2: decode backpressure for three cycles
        cons_q.delete(); acc_q.delete();
        idr_pct = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req_low", 32'(s_req), 32'd0);
        end
        chk("t2_ifid_pc_held", s_ifid_pc, 32'h10);
        idr_pct = 100;
        wait_cons(3, 20, "t2_resume");
        if (cons_q.size() >= 3) begin
            chk("t2_resume0", cons_q[0], 32'h10);
            chk("t2_resume2", cons_q[2], 32'h18);
        end
        wait_acc(1, 20, "t2_next_req");
        if (acc_q.size() >= 1) chk("t2_next_addr", acc_q[0], 32'h18);

        // 3: jal redirect while a read is in flight
        lat_min = 3; lat_max = 3;
        k = 0;
        while (!(mem_busy && mem_cnt > 0) && k < 20) begin step(); k++; end
        redirect(2'd1, 32'h0000_0100);
        wait_acc(1, 20, "t3_accept");
        if (acc_q.size() >= 1) chk("t3_addr", acc_q[0], 32'h100);
        wait_cons(1, 30, "t3_consume");
        if (cons_q.size() >= 1) chk("t3_first_pc", cons_q[0], 32'h100);

        // 4: jalr clears bit 0
        lat_min = 1; lat_max = 2;
        redirect(2'd2, 32'h0000_0203);
        wait_acc(1, 20, "t4_accept");
        if (acc_q.size() >= 1) chk("t4_addr", acc_q[0], 32'h202);

        // 5: unaccepted request redirected to a branch target
        ready_pct = 0;
        k = 0;
        step();
        while (!s_req && k < 20) begin step(); k++; end
        held_addr = s_addr;
        step();
        chk("t5_addr_hold", s_addr, held_addr);
        redirect(2'd3, 32'h0000_0040);
        step();
        chk("t5_req", 32'(s_req), 32'd1);
        chk("t5_addr", s_addr, 32'h40);
        ready_pct = 100;
        cons_q.delete();
        wait_cons(1, 20, "t5_consume");
        if (cons_q.size() >= 1) chk("t5_first_pc", cons_q[0], 32'h40);

        // 6: PC wrap and flush counting
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) step();
        redirect(2'd1, 32'hFFFF_FFFC);
        wait_acc(2, 20, "t6_accept");
        if (acc_q.size() >= 2) begin
            chk("t6_addr_top", acc_q[0], 32'hFFFF_FFFC);
            chk("t6_addr_wrap", acc_q[1], 32'h0);
        end
        redirect(2'd0, 32'h0);
        step();
`ifdef FETCH_PERF_CNT_EN
        chk("t6_flush_count", flush_count, 32'd2);
`endif

        // reset while a read is in flight; stale response must be ignored
        lat_min = 3; lat_max = 3;
        k = 0;
        while (!(mem_busy && mem_cnt > 0) && k < 20) begin step(); k++; end
        do_reset();

        // randomized traffic
        ready_pct = 70; idr_pct = 70; lat_min = 1; lat_max = 4; rd_pct = 4;
        cons_before = n_cons;
        repeat (3000) step();
        if (n_cons - cons_before < 100) begin
            checks++;
            $display("FAIL random_progress: got %0d consumes expected >= 100", n_cons - cons_before);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("flush_count", flush_count, 32'(n_flush));
        chk("fetch_count_ge_consumed", 32'(fetch_count >= 32'(n_cons)), 32'd1);
`endif
        rd_pct = 0;
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
